// File: rtl/cnn_pkg.sv
// Shared sizes, state encoding and address helper for the
// CNN window sequencer and its fetch unit.
package cnn_pkg;

    localparam int IMG_W    = 28;
    localparam int K        = 5;
    localparam int OUT_W    = IMG_W - K + 1;
    localparam int PIX_W    = 8;
    localparam int WIN_BITS = K * K * PIX_W;
    localparam int ADDR_W   = 10;
    localparam int POS_W    = 5;
    localparam int RES_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_RES,
        FIN,
        ERR
    } state_t;

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [POS_W-1:0] row,
        input logic [POS_W-1:0] col
    );
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/cnn_window_sequencer_if.sv
// Sequencer-side bus: RAM read port, window handshake, classifier result.
// master = sequencer, slave = RAM + classifier.
interface cnn_window_sequencer_if;
    import cnn_pkg::*;

    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [PIX_W-1:0]    mem_rdata;
    logic                cnn_start;
    logic                win_valid;
    logic                win_ready;
    logic [POS_W-1:0]    cnn_x;
    logic [POS_W-1:0]    cnn_y;
    logic [WIN_BITS-1:0] cnn_imgin;
    logic                cnn_done;
    logic [RES_W-1:0]    cnn_out;

    modport master (
        output mem_rd, mem_addr, cnn_start, win_valid,
        output cnn_x, cnn_y, cnn_imgin,
        input  mem_rdata, win_ready, cnn_done, cnn_out
    );

    modport slave (
        input  mem_rd, mem_addr, cnn_start, win_valid,
        input  cnn_x, cnn_y, cnn_imgin,
        output mem_rdata, win_ready, cnn_done, cnn_out
    );

endinterface

// File: rtl/cnn_win_fetch.sv
// Window fetch: issues 25 reads, delays read-valid by MEM_LAT, assembles 200b.
// Ports: i_en (FETCH), i_x/i_y window origin, o_rd/o_addr/i_rdata RAM, o_last, o_imgin.
module cnn_win_fetch
    import cnn_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [POS_W-1:0]    i_x,
    input  logic [POS_W-1:0]    i_y,
    output logic                o_rd,
    output logic [ADDR_W-1:0]   o_addr,
    input  logic [PIX_W-1:0]    i_rdata,
    output logic                o_last,
    output logic [WIN_BITS-1:0] o_imgin
);

    localparam int NPIX  = K * K;
    localparam int CNT_W = $clog2(NPIX + 1);

    logic [CNT_W-1:0]    r_iss;
    logic [CNT_W-1:0]    r_rcv;
    logic [2:0]          r_i;
    logic [2:0]          r_j;
    logic [MEM_LAT-1:0]  r_vld;
    logic [WIN_BITS-1:0] r_img;
    logic                w_cap;

    assign o_rd    = i_en && (r_iss < CNT_W'(NPIX));
    assign o_addr  = pix_addr(i_y + POS_W'(r_i), i_x + POS_W'(r_j));
    assign w_cap   = r_vld[MEM_LAT-1];
    assign o_last  = w_cap && (r_rcv == CNT_W'(NPIX - 1));
    assign o_imgin = r_img;

    // Counters idle at zero outside FETCH so a new window starts at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_iss <= '0;
            r_rcv <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_vld <= '0;
        end else if (!i_en) begin
            r_iss <= '0;
            r_rcv <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_vld <= '0;
        end else begin
            r_vld <= (r_vld << 1) | MEM_LAT'(o_rd);
            if (o_rd) begin
                r_iss <= r_iss + CNT_W'(1);
                if (r_j == 3'(K - 1)) begin
                    r_j <= '0;
                    r_i <= r_i + 3'd1;
                end else begin
                    r_j <= r_j + 3'd1;
                end
            end
            if (w_cap) begin
                r_rcv <= r_rcv + CNT_W'(1);
            end
        end
    end

    // Shift in at LSB: the first pixel ends up in the top byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_img <= '0;
        end else if (w_cap) begin
            r_img <= {r_img[WIN_BITS-PIX_W-1:0], i_rdata};
        end
    end

endmodule

// File: rtl/cnn_window_sequencer.sv
// Front-end controller: walks all 24x24 windows, then waits for the result.
// Ports: i_clk, i_rst_n, i_start, m_bus (RAM/window/result), o_busy/o_done/o_err/o_result.
module cnn_window_sequencer
    import cnn_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int WAIT_MAX = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    cnn_window_sequencer_if.master  m_bus,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [RES_W-1:0]        o_result
);

    localparam int WT_W = $clog2(WAIT_MAX + 1);

    state_t           r_state;
    state_t           w_next;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic [WT_W-1:0]  r_wait;
    logic [RES_W-1:0] r_result;
    logic             r_cnn_start;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last_pos;
    logic             w_fetch_en;
    logic             w_fetch_last;

    cnn_win_fetch #(
        .MEM_LAT (MEM_LAT)
    ) u_fetch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_fetch_en),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_rd    (m_bus.mem_rd),
        .o_addr  (m_bus.mem_addr),
        .i_rdata (m_bus.mem_rdata),
        .o_last  (w_fetch_last),
        .o_imgin (m_bus.cnn_imgin)
    );

    assign w_fetch_en = (r_state == FETCH);
    assign w_accept   = i_start && (r_state inside {IDLE, FIN, ERR});
    assign w_xfer     = (r_state == ISSUE) && m_bus.win_ready;
    assign w_last_pos = (r_x == POS_W'(OUT_W - 1)) &&
                        (r_y == POS_W'(OUT_W - 1));

    assign m_bus.cnn_start = r_cnn_start;
    assign m_bus.cnn_x     = r_x;
    assign m_bus.cnn_y     = r_y;
    assign o_result        = r_result;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        o_err           = 1'b0;
        m_bus.win_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) w_next = FETCH;
            end
            FIN: begin
                o_done = 1'b1;
                if (i_start) w_next = FETCH;
            end
            ERR: begin
                o_err = 1'b1;
                if (i_start) w_next = FETCH;
            end
            FETCH: begin
                o_busy = 1'b1;
                if (w_fetch_last) w_next = ISSUE;
            end
            ISSUE: begin
                o_busy          = 1'b1;
                m_bus.win_valid = 1'b1;
                if (m_bus.win_ready) begin
                    w_next = w_last_pos ? WAIT_RES : FETCH;
                end
            end
            WAIT_RES: begin
                o_busy = 1'b1;
                if (m_bus.cnn_done) begin
                    w_next = FIN;
                end else if (r_wait == WT_W'(WAIT_MAX - 1)) begin
                    w_next = ERR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // r_wait counts whole cycles spent in WAIT_RES (0 on the first one).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_wait      <= '0;
            r_result    <= '0;
            r_cnn_start <= 1'b0;
        end else begin
            r_cnn_start <= w_accept;
            if (w_accept) begin
                r_x      <= '0;
                r_y      <= '0;
                r_result <= '0;
            end else if (w_xfer && !w_last_pos) begin
                if (r_x == POS_W'(OUT_W - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + POS_W'(1);
                end else begin
                    r_x <= r_x + POS_W'(1);
                end
            end
            if (r_state == WAIT_RES) begin
                if (m_bus.cnn_done) r_result <= m_bus.cnn_out;
                r_wait <= r_wait + WT_W'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_window_sequencer.sv
// Scoreboard bench: expected windows queued at START, popped on each transfer.
// Second instance uses MEM_LAT=3 and must produce identical windows.
module tb_cnn_window_sequencer;
    import cnn_pkg::*;

    localparam int WMAX = 256;
    localparam int NWIN = OUT_W * OUT_W;
    localparam int TMO  = 40000;

    typedef struct packed {
        logic [POS_W-1:0]    x;
        logic [POS_W-1:0]    y;
        logic [WIN_BITS-1:0] img;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, rst3_n, start, start3;
    logic             busy, done, err, busy3, done3, err3;
    logic [RES_W-1:0] result, result3;

    int n_chk  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int n_x    = 0;
    int n_x3   = 0;
    int t_last = 0;
    int t_go   = 0;
    win_t q[$];
    win_t q3[$];

    always @(posedge clk) cyc <= cyc + 1;

    cnn_window_sequencer_if bus ();
    cnn_window_sequencer_if bus3 ();

    cnn_window_sequencer #(
        .MEM_LAT  (1),
        .WAIT_MAX (WMAX)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .m_bus    (bus),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .o_result (result)
    );

    cnn_window_sequencer #(
        .MEM_LAT  (3),
        .WAIT_MAX (WMAX)
    ) dut3 (
        .i_clk    (clk),
        .i_rst_n  (rst3_n),
        .i_start  (start3),
        .m_bus    (bus3),
        .o_busy   (busy3),
        .o_done   (done3),
        .o_err    (err3),
        .o_result (result3)
    );

    // RAM models: pix[a] = a % 256, read latency 1 and 3.
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a3 [3];
    always @(posedge clk) begin
        a1    <= bus.mem_addr;
        a3[0] <= bus3.mem_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign bus.mem_rdata  = PIX_W'(a1);
    assign bus3.mem_rdata = PIX_W'(a3[2]);

    task automatic chk(input string tag,
                       input logic [WIN_BITS-1:0] got,
                       input logic [WIN_BITS-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIN_BITS-1:0] exp_img(input int x, input int y);
        logic [WIN_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                v[WIN_BITS-1-PIX_W*(K*i+j) -: PIX_W] =
                    PIX_W'(((y + i) * IMG_W + x + j) % 256);
            end
        end
        return v;
    endfunction

    task automatic push_run(input bit third);
        for (int y = 0; y < OUT_W; y++) begin
            for (int x = 0; x < OUT_W; x++) begin
                win_t w;
                w.x   = POS_W'(x);
                w.y   = POS_W'(y);
                w.img = exp_img(x, y);
                if (third) q3.push_back(w);
                else       q.push_back(w);
            end
        end
    endtask

    always @(negedge clk) begin : mon1
        win_t e;
        if (bus.mem_rd) chk("rd_outside_busy", busy, 1);
        if (bus.win_valid && bus.win_ready) begin
            n_x++;
            t_last = cyc;
            if (q.size() == 0) begin
                chk("dut_extra_xfer", 0, 1);
            end else begin
                e = q.pop_front();
                chk("dut_x", bus.cnn_x, e.x);
                chk("dut_y", bus.cnn_y, e.y);
                chk("dut_imgin", bus.cnn_imgin, e.img);
            end
        end
    end

    always @(negedge clk) begin : mon3
        win_t e;
        if (bus3.win_valid && bus3.win_ready) begin
            n_x3++;
            if (q3.size() == 0) begin
                chk("dut3_extra_xfer", 0, 1);
            end else begin
                e = q3.pop_front();
                chk("dut3_x", bus3.cnn_x, e.x);
                chk("dut3_y", bus3.cnn_y, e.y);
                chk("dut3_imgin", bus3.cnn_imgin, e.img);
            end
        end
    end

    task automatic go();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("cnn_start_pulse", bus.cnn_start, 1);
        chk("busy_on_start", busy, 1);
        chk("done_clr", done, 0);
        chk("err_clr", err, 0);
        chk("result_clr", result, 0);
        t_go = cyc;
        @(negedge clk);
        chk("cnn_start_1cyc", bus.cnn_start, 0);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.win_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("valid_seen", ok, 1);
    endtask

    task automatic wait_xfers(input int n, input string tag);
        int k;
        k = 0;
        while (n_x < n && k < TMO) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_x >= n, 1);
    endtask

    initial begin
        int k;
        int t_err;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        bus.win_ready  = 1'b0;
        bus.cnn_done   = 1'b0;
        bus.cnn_out    = '0;
        bus3.win_ready = 1'b1;
        bus3.cnn_done  = 1'b0;
        bus3.cnn_out   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", bus.win_valid, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_cnn_start", bus.cnn_start, 0);
        chk("rst_imgin", bus.cnn_imgin, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rst3_n = 1'b1;

        // Run A: stalled first window, full raster, result 7.
        push_run(0);
        n_x = 0;
        go();
        wait_valid();
        chk("fetch_latency", cyc - t_go, 26);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", bus.win_valid, 1);
            chk("stall_x", bus.cnn_x, q[0].x);
            chk("stall_y", bus.cnn_y, q[0].y);
            chk("stall_imgin", bus.cnn_imgin, q[0].img);
            chk("win0_b0", bus.cnn_imgin[199:192], 8'd0);
            chk("win0_b1", bus.cnn_imgin[191:184], 8'd1);
            chk("win0_b5", bus.cnn_imgin[159:152], 8'd28);
            chk("win0_b24", bus.cnn_imgin[7:0], 8'd116);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.win_ready = 1'b1;
        wait_xfers(NWIN, "run_a_done");
        chk("run_a_xfers", n_x, NWIN);
        chk("run_a_q_empty", q.size(), 0);
        @(negedge clk);
        chk("wait_res_busy", busy, 1);
        chk("wait_res_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.cnn_done = 1'b1;
        bus.cnn_out  = 4'd7;
        @(posedge clk); #1;
        bus.cnn_done = 1'b0;
        bus.cnn_out  = '0;
        @(negedge clk);
        chk("fin_result", result, 7);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_err", err, 0);

        // Run B: START and stray CNN_DONE mid-run ignored, then timeout.
        push_run(0);
        n_x = 0;
        go();
        wait_xfers(100, "run_b_100");
        k = 0;
        while (!bus.mem_rd && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("run_b_in_fetch", bus.mem_rd, 1);
        @(posedge clk); #1;
        start        = 1'b1;
        bus.cnn_done = 1'b1;
        bus.cnn_out  = 4'd9;
        @(posedge clk); #1;
        start        = 1'b0;
        bus.cnn_done = 1'b0;
        bus.cnn_out  = '0;
        @(negedge clk);
        chk("restart_no_pulse", bus.cnn_start, 0);
        chk("restart_busy", busy, 1);
        wait_xfers(NWIN, "run_b_done");
        chk("run_b_xfers", n_x, NWIN);
        t_err = -1;
        for (int i = 0; i < WMAX + 50; i++) begin
            @(negedge clk);
            if (err) begin
                t_err = cyc;
                break;
            end
        end
        chk("err_timing", t_err - t_last, WMAX + 1);
        chk("err_result", result, 0);
        chk("err_done", done, 0);
        chk("err_busy", busy, 0);

        // Run C: reset mid-ISSUE, then rerun alongside MEM_LAT=3.
        push_run(0);
        n_x = 0;
        bus.win_ready = 1'b1;
        go();
        wait_xfers(50, "run_c_50");
        @(posedge clk); #1 bus.win_ready = 1'b0;
        wait_valid();
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.win_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mem_rd", bus.mem_rd, 0);
        chk("abort_x", bus.cnn_x, 0);
        chk("abort_y", bus.cnn_y, 0);
        chk("abort_imgin", bus.cnn_imgin, 0);
        chk("abort_result", result, 0);
        chk("abort_err", err, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.win_ready = 1'b1;
        push_run(0);
        push_run(1);
        n_x  = 0;
        n_x3 = 0;
        @(posedge clk); #1;
        start  = 1'b1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start3 = 1'b0;
        k = 0;
        while ((n_x < NWIN || n_x3 < NWIN) && k < TMO) begin
            @(negedge clk);
            k++;
        end
        chk("run_c_xfers", n_x, NWIN);
        chk("run_c_xfers_lat3", n_x3, NWIN);
        chk("run_c_q_empty", q.size() + q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
